// File: rtl/counter24_if.sv
// counter24_if: display-side bundle of the hours counter.
//   Q  : packed BCD count, Q[7:4] tens digit (0..2), Q[3:0] units digit (0..9)
//   CO : carry-out, high while the count is 23
// master modport drives the bundle (the counter); slave modport observes it
// (display / next cascade stage).
interface counter24_if;
  logic [7:0] Q;
  logic       CO;

  modport master (
    output Q,
    output CO
  );

  modport slave (
    input Q,
    input CO
  );
endinterface

// File: rtl/counter24.sv
// counter24: free-running two-digit BCD modulo-24 counter (hours field).
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset, forces the count to 8'h00
//   bus : counter24_if.master carrying Q (packed BCD count) and CO
//         (carry-out, high while Q == 8'h23)
// Any illegal count (units > 9, tens > 2, or above 23) returns to 8'h00 on
// the next edge, so an upset or an un-reset power-up heals by itself.
module counter24 (
  input  logic        clk,
  input  logic        rst,
  counter24_if.master bus
);

  // Count register; both BCD digits live here so Q is a pure register output.
  logic [7:0] q_r;

  logic [3:0] units_s;
  logic [3:0] tens_s;
  logic       legal_s;
  logic       terminal_s;
  logic       tens_en_s;
  logic [3:0] units_next_s;
  logic [3:0] tens_next_s;

  // True when the packed value is a reachable BCD count 00..23.
  function automatic logic count_legal(input logic [7:0] q);
    logic ok;
    ok = (q[3:0] <= 4'd9) && (q[7:4] <= 4'd2) && (q <= 8'h23);
    return ok;
  endfunction

  assign units_s    = q_r[3:0];
  assign tens_s     = q_r[7:4];
  assign legal_s    = count_legal(q_r);
  // Shared terminal-count decode; clears both digit stages at 23.
  assign terminal_s = (q_r == 8'h23);
  // Units stage enables the tens stage when it wraps.
  assign tens_en_s  = (units_s == 4'd9);

  // Units digit stage: 0..9, cleared at terminal count or on illegal state.
  always_comb begin
    units_next_s = 4'd0;
    if (!legal_s || terminal_s) begin
      units_next_s = 4'd0;
    end else if (tens_en_s) begin
      units_next_s = 4'd0;
    end else begin
      units_next_s = units_s + 4'd1;
    end
  end

  // Tens digit stage: advances on units wrap, cleared at terminal count or
  // on illegal state.
  always_comb begin
    tens_next_s = 4'd0;
    if (!legal_s || terminal_s) begin
      tens_next_s = 4'd0;
    end else if (tens_en_s) begin
      tens_next_s = tens_s + 4'd1;
    end else begin
      tens_next_s = tens_s;
    end
  end

  // Count register with synchronous reset taking priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 8'h00;
    end else begin
      q_r <= {tens_next_s, units_next_s};
    end
  end

  assign bus.Q  = q_r;
  // CO decodes the registered count only, so it tracks Q with no extra latency.
  assign bus.CO = terminal_s;

endmodule

// File: tb/tb_counter24.sv
// tb_counter24: self-checking bench for counter24. A reference model keeps
// the hour as a plain integer 0..23 and converts it to packed BCD for
// comparison; directed steps follow the test plan, then a randomized run
// with sporadic resets.
module tb_counter24;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   model_h;     // reference hour, 0..23
  int   co_count;
  int   co_first;
  int   co_second;

  counter24_if bus ();

  counter24 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int h);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(h / 10);
    u = 4'(h % 10);
    return {t, u};
  endfunction

  task automatic check(input string tag, input logic [7:0] exp_q, input logic exp_co);
    checks = checks + 1;
    assert (bus.Q === exp_q) else begin
      failures = failures + 1;
      $error("FAIL %s Q observed=%h expected=%h", tag, bus.Q, exp_q);
    end
    checks = checks + 1;
    assert (bus.CO === exp_co) else begin
      failures = failures + 1;
      $error("FAIL %s CO observed=%b expected=%b", tag, bus.CO, exp_co);
    end
  endtask

  // One clock: drive rst, advance the model at the edge, check at negedge.
  task automatic tick(input logic r, input string tag);
    rst = r;
    @(posedge clk);
    if (r) model_h = 0;
    else   model_h = (model_h + 1) % 24;
    @(negedge clk);
    check(tag, to_bcd(model_h), (model_h == 23) ? 1'b1 : 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_h  = 0;
    rst      = 1'b1;

    // Reset held for 5 edges.
    for (int i = 0; i < 5; i++) tick(1'b1, "reset_hold");

    // Release: 01 then up to 10, passing 09 -> 10.
    for (int i = 0; i < 10; i++) tick(1'b0, "count_0_10");
    check("reach_10", 8'h10, 1'b0);

    // Up to 19, then 20, then 23 with CO.
    for (int i = 0; i < 9; i++) tick(1'b0, "count_to_19");
    check("reach_19", 8'h19, 1'b0);
    tick(1'b0, "wrap_19_20");
    check("reach_20", 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, "count_to_23");
    check("reach_23", 8'h23, 1'b1);
    tick(1'b0, "wrap_23_00");
    check("rollover", 8'h00, 1'b0);

    // 48 clocks: CO high exactly twice, 24 clocks apart.
    co_count  = 0;
    co_first  = -1;
    co_second = -1;
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, "co_window");
      if (bus.CO === 1'b1) begin
        co_count = co_count + 1;
        if (co_first < 0) co_first = i;
        else co_second = i;
      end
    end
    checks = checks + 1;
    assert (co_count == 2) else begin
      failures = failures + 1;
      $error("FAIL co_pulses observed=%0d expected=%0d", co_count, 2);
    end
    checks = checks + 1;
    assert ((co_second - co_first) == 24) else begin
      failures = failures + 1;
      $error("FAIL co_spacing observed=%0d expected=%0d", co_second - co_first, 24);
    end

    // Mid-count reset at 15.
    while (model_h != 15) tick(1'b0, "seek_15");
    check("at_15", 8'h15, 1'b0);
    tick(1'b1, "midreset");
    check("midreset_00", 8'h00, 1'b0);
    tick(1'b0, "resume_01");
    tick(1'b0, "resume_02");
    check("resume_02_lit", 8'h02, 1'b0);

    // Illegal-state recovery: 2A, then 35.
    force dut.q_r = 8'h2A;
    #1;
    check("illegal_2a_hold", 8'h2A, 1'b0);
    release dut.q_r;
    model_h = 23;  // next model step lands on 0, the recovery value
    tick(1'b0, "recover_2a");
    check("recover_2a_lit", 8'h00, 1'b0);

    force dut.q_r = 8'h35;
    #1;
    check("illegal_35_hold", 8'h35, 1'b0);
    release dut.q_r;
    model_h = 23;
    tick(1'b0, "recover_35");
    tick(1'b0, "after_recover");

    // Randomized run with occasional resets.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, "random");
    end

    // Reset on the 23 -> 00 edge.
    while (model_h != 23) tick(1'b0, "seek_23");
    tick(1'b1, "reset_at_23");
    check("reset_at_23_lit", 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter24.md
Name: counter24

Overview:
- Free-running two-digit BCD modulo-24 counter, 00..23, for the hours field of the digital clock (MyClock).
- Advances once per rising clock edge.
- Drives an 8-bit packed-BCD display value and a carry-out flag.
- The carry-out marks the terminal count (23) so a higher stage (day counter / cascade) can advance on the 23->00 rollover.

Parameters:
- none (modulus fixed at 24, BCD encoding fixed)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous and active-high; one clock, reset is synchronous and active-high
- Q    output 8  packed BCD count; Q[7:4] = tens digit (0..2), Q[3:0] = units digit (0..9)
- CO   output 1  carry-out; high while the count is 23

Behaviour:
- Reset
  - rst sampled only at the rising edge of clk.
  - rst=1 at an edge -> Q <= 8'h00 on that edge.
  - rst has priority over counting.
  - Holding rst keeps Q=8'h00, CO=0.
  - No asynchronous path.
- Counting: each rising edge with rst=0 advances Q by one in BCD.
  - Units digit counts 0..9; on 9 it goes to 0 and tens increments.
  - Tens digit counts 0..2.
  - At Q=8'h23 the next edge yields Q=8'h00 (both digits clear).
  - 8'h09 -> 8'h10; 8'h19 -> 8'h20; 8'h20 -> 8'h21 ... 8'h23 -> 8'h00.
  - Sequence length is exactly 24 clocks per wrap.
- Count encoding
  - Q never takes binary values 0x0A..0x0F in the units nibble.
  - Q never exceeds 8'h23 in normal operation.
- CO
  - Combinational decode: CO = (Q == 8'h23).
  - High for exactly one full clock period per 24-cycle wrap, aligned with Q=23.
  - Low in every other state and during reset.
  - No extra latency: CO rises in the same cycle Q becomes 23.
  - CO falls in the same cycle Q becomes 00.
- Illegal-state recovery (e.g. after X/upset)
  - Any Q with a units nibble >9, a tens nibble >2, or value >8'h23 goes to 8'h00 on the next rising edge with rst=0.
  - CO=0 while Q is illegal.
- Timing
  - Q is registered; no combinational path from rst to Q.
  - CO depends only on registered Q.
- Structure
  - Two cascaded BCD digit stages: units stage enables the tens stage on units==9.
  - A shared terminal-count decode forces both stages to 0 at 23.
- Simultaneous events: rst=1 at the 23->00 edge -> Q=00, same result; CO drops.
- Power-up before first reset: Q undefined, then follows the recovery rule.

Test Plan:
- Hold rst=1 for 100 ns (5 edges, 20 ns clock period) -> Q=8'h00, CO=0 throughout; release rst -> first edge gives Q=8'h01.
- From 00, apply 10 edges -> Q passes 01..09 then 8'h10 (never 8'h0A); CO=0.
- Continue to Q=8'h19, one edge -> 8'h20; three more edges -> 8'h23 with CO=1 in that cycle only.
- At Q=8'h23 apply one edge -> Q=8'h00, CO=0; over 48 consecutive clocks CO is high exactly 2 cycles, 24 clocks apart.
- Mid-count reset: at Q=8'h15 assert rst for one edge -> Q=8'h00 on that edge; deassert -> resumes 01, 02.
- Force illegal Q=8'h2A or 8'h35 (via bench force/release) with rst=0 -> next edge Q=8'h00, CO=0 meanwhile.
